// File: rtl/bus_arbiter4_rr_if.sv
// Handshake bundle between the four bus sources and the round-robin arbiter.
// The arbiter side uses the master modport and the sources use the slave modport.
interface bus_arbiter4_rr_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       bus_en;
    logic       busy;
    logic       preempt;

    modport master (
        input  req,
        output grant,
        output sel,
        output bus_en,
        output busy,
        output preempt
    );

    modport slave (
        output req,
        input  grant,
        input  sel,
        input  bus_en,
        input  busy,
        input  preempt
    );
endinterface

// File: rtl/bus_arbiter4_rr.sv
// Round-robin arbiter for a shared 4-source tri-state line. It bounds how long one
// owner may hold the line and inserts idle turnaround cycles between owners.
module bus_arbiter4_rr #(
    parameter int MAX_HOLD  = 8,
    parameter int TA_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    bus_arbiter4_rr_if.master  bus
);

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [1:0] TA_LAST = (TA_CYCLES > 0) ? 2'(TA_CYCLES - 1) : 2'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        ta_cnt;
    logic [1:0]        last_ptr;

    logic [3:0]        grant_q;
    logic [1:0]        sel_q;
    logic              bus_en_q;
    logic              busy_q;
    logic              preempt_q;

    logic [1:0]        winner;
    logic              owner_req;
    logic              hold_expired;

    // Scan starts just after the previous owner, so that owner ranks lowest.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] cand;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (r[cand]) rr_pick = cand;
        end
    endfunction

    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the missing case.
    always_comb begin
        winner       = rr_pick(bus.req, last_ptr);
        owner_req    = bus.req[sel_q];
        hold_expired = (hold_cnt == HOLD_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            ta_cnt    <= '0;
            last_ptr  <= 2'd3;
            grant_q   <= '0;
            sel_q     <= '0;
            bus_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_q  <= 4'b0001 << winner;
                        sel_q    <= winner;
                        bus_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end

                GRANT: begin
                    if (!owner_req || hold_expired) begin
                        grant_q   <= '0;
                        bus_en_q  <= 1'b0;
                        last_ptr  <= sel_q;
                        // A simultaneous drop of req is an ordinary release.
                        preempt_q <= hold_expired && owner_req;
                        if (TA_CYCLES > 0) begin
                            ta_cnt <= '0;
                            busy_q <= 1'b1;
                            state  <= TURN;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                TURN: begin
                    if (ta_cnt == TA_LAST) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        ta_cnt <= ta_cnt + 1'b1;
                    end
                end

                default: begin
                    grant_q  <= '0;
                    bus_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.bus_en  = bus_en_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter4_rr.sv
// Randomized bench for bus_arbiter4_rr: three parameterisations run side by side
// against an ownership-level reference model of the arbitration rules.
module tb_bus_arbiter4_rr;

    localparam int N_DUT = 3;
    localparam int MH [N_DUT] = '{8, 4, 3};
    localparam int TA [N_DUT] = '{1, 1, 0};
    localparam int N_CYCLES = 1200;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bus_arbiter4_rr_if if0 ();
    bus_arbiter4_rr_if if1 ();
    bus_arbiter4_rr_if if2 ();

    bus_arbiter4_rr #(.MAX_HOLD(8), .TA_CYCLES(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    bus_arbiter4_rr #(.MAX_HOLD(4), .TA_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    bus_arbiter4_rr #(.MAX_HOLD(3), .TA_CYCLES(0)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: who owns the line, for how many cycles, and who went last.
    typedef enum int {PH_IDLE, PH_OWNED, PH_GAP} phase_t;
    phase_t     phase     [N_DUT];
    int         owner     [N_DUT];
    int         held      [N_DUT];
    int         gap_left  [N_DUT];
    int         last_own  [N_DUT];
    int         exp_sel   [N_DUT];
    bit         exp_pre   [N_DUT];
    logic [3:0] req_v     [N_DUT];
    int         n_preempt [N_DUT];
    int         n_ties    [N_DUT];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [8:0] observe(input int i);
        case (i)
            0:       observe = {if0.grant, if0.sel, if0.bus_en, if0.busy, if0.preempt};
            1:       observe = {if1.grant, if1.sel, if1.bus_en, if1.busy, if1.preempt};
            default: observe = {if2.grant, if2.sel, if2.bus_en, if2.busy, if2.preempt};
        endcase
    endfunction

    function automatic logic [8:0] expected_outputs(input int i);
        logic [3:0] g;
        g = (phase[i] == PH_OWNED) ? 4'(1 << owner[i]) : 4'd0;
        expected_outputs = {g, 2'(exp_sel[i]), phase[i] == PH_OWNED,
                            phase[i] != PH_IDLE, exp_pre[i]};
    endfunction

    task automatic drive_req(input int i, input logic [3:0] r);
        req_v[i] = r;
        case (i)
            0:       if0.req = r;
            1:       if1.req = r;
            default: if2.req = r;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_DUT; i++) begin
            phase[i]    = PH_IDLE;
            owner[i]    = 0;
            held[i]     = 0;
            gap_left[i] = 0;
            last_own[i] = 3;
            exp_sel[i]  = 0;
            exp_pre[i]  = 1'b0;
        end
    endtask

    // One clock edge of the arbitration rules, using the requests seen at that edge.
    task automatic model_step(input int i);
        logic [3:0] r;
        bit found;
        int cand;
        r = req_v[i];
        exp_pre[i] = 1'b0;
        case (phase[i])
            PH_IDLE: begin
                if (r != 4'd0) begin
                    found = 1'b0;
                    for (int k = 1; k <= 4; k++) begin
                        cand = (last_own[i] + k) % 4;
                        if (!found && r[cand]) begin
                            owner[i] = cand;
                            found = 1'b1;
                        end
                    end
                    exp_sel[i] = owner[i];
                    held[i]    = 1;
                    phase[i]   = PH_OWNED;
                end
            end
            PH_OWNED: begin
                if (!r[owner[i]] || held[i] == MH[i]) begin
                    exp_pre[i]  = r[owner[i]];
                    last_own[i] = owner[i];
                    if (exp_pre[i]) n_preempt[i]++;
                    if (!r[owner[i]] && held[i] == MH[i]) n_ties[i]++;
                    if (TA[i] > 0) begin
                        gap_left[i] = TA[i];
                        phase[i]    = PH_GAP;
                    end else begin
                        phase[i] = PH_IDLE;
                    end
                end else begin
                    held[i]++;
                end
            end
            default: begin
                gap_left[i]--;
                if (gap_left[i] == 0) phase[i] = PH_IDLE;
            end
        endcase
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < N_DUT; i++)
            check($sformatf("%s_dut%0d", tag, i), 32'(observe(i)), 32'd0);
    endtask

    // Reset asserted between edges with every source requesting.
    task automatic mid_cycle_reset();
        for (int i = 0; i < N_DUT; i++) drive_req(i, 4'hF);
        #1 rst = 1'b1;
        #1 check_reset_values("async_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_reset_values("held_reset");
        #1 rst = 1'b0;
    endtask

    function automatic logic [3:0] next_req(input int i, input int mode);
        logic [3:0] r;
        r = req_v[i];
        case (mode)
            1: r = 4'hF;
            2: begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            default: begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
                if (phase[i] == PH_OWNED && held[i] == MH[i] && $urandom_range(0, 1) == 1)
                    r[owner[i]] = 1'b0;
            end
        endcase
        return r;
    endfunction

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            drive_req(i, 4'd0);
            n_preempt[i] = 0;
            n_ties[i]    = 0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("power_on_reset");
        #1 rst = 1'b0;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            if (!rst)
                for (int i = 0; i < N_DUT; i++) model_step(i);
            @(negedge clk);
            for (int i = 0; i < N_DUT; i++)
                check($sformatf("cyc%0d_dut%0d_outputs", cyc, i),
                      32'(observe(i)), 32'(expected_outputs(i)));
            if (cyc == 250 || cyc == 610 || cyc == 955) begin
                mid_cycle_reset();
            end else begin
                for (int i = 0; i < N_DUT; i++)
                    drive_req(i, next_req(i, (cyc / 120) % 3));
            end
        end

        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("dut%0d_saw_preempt", i), 32'(n_preempt[i] > 0), 32'd1);
        end
        check("dut1_saw_timeout_release_tie", 32'(n_ties[1] > 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
